mc_control_fsm: RTL and testbench

//  Parametrised multi-cycle RV32I sequencer; successor to the fixed control_unit. Drives the top-level datapath muxes/enables.

---
 rtl/rv32i_pkg.sv | 58 +++++
 rtl/mc_wait_timer.sv | 35 +++
 rtl/mc_control_fsm.sv | 215 +++++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - opcodes, sequencer states and mux select encodings for the multi-cycle RV32I core
package rv32i_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXECUTE,
        MEM,
        WB,
        TRAP
    } state_t;

    localparam logic [1:0] SRC_A_PC       = 2'b00;
    localparam logic [1:0] SRC_A_REG      = 2'b01;
    localparam logic [1:0] SRC_A_FETCH_PC = 2'b10;
    localparam logic [1:0] SRC_A_ZERO     = 2'b11;

    localparam logic [1:0] SRC_B_REG  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_FUNCT  = 2'b01;
    localparam logic [1:0] ALU_BRANCH = 2'b10;

    localparam logic [1:0] WB_ALU_OUT = 2'b00;
    localparam logic [1:0] WB_MEM     = 2'b01;
    localparam logic [1:0] WB_IMM     = 2'b10;
    localparam logic [1:0] WB_PC      = 2'b11;

    localparam logic [1:0] PC_ALU       = 2'b00;
    localparam logic [1:0] PC_ALU_OUT   = 2'b01;
    localparam logic [1:0] PC_ALU_ALIGN = 2'b10;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_IMEM    = 2'b10;
    localparam logic [1:0] CAUSE_DMEM    = 2'b11;

    function automatic logic is_legal(input logic [6:0] opc);
        case (opc)
            OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
            OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: is_legal = 1'b1;
            default:                               is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// rtl/mc_wait_timer.sv - counts ready-low cycles of a memory wait and flags the timeout
module mc_wait_timer #(
    parameter int LIMIT = 16
) (
    input  logic i_clk,
    input  logic i_clear,
    input  logic i_tick,
    output logic o_expired
);

    generate
        if (LIMIT == 0) begin : g_never
            logic w_unused;
            assign w_unused  = ^{i_clk, i_clear, i_tick};
            assign o_expired = 1'b0;
        end else begin : g_count
            localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
            localparam logic [W-1:0] LAST = W'(LIMIT - 1);
            logic [W-1:0] r_count;

            // Count ready-low cycles since the wait began; saturate at the last legal value
            always_ff @(posedge i_clk) begin
                if (i_clear) begin
                    r_count <= '0;
                end else if (i_tick && (r_count != LAST)) begin
                    r_count <= r_count + W'(1);
                end
            end

            // The LIMIT-th consecutive ready-low cycle expires; ready in that cycle suppresses it
            assign o_expired = i_tick && !i_clear && (r_count == LAST);
        end
    endgenerate

endmodule

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multi-cycle RV32I sequencer with memory handshakes, timeouts and traps
module mc_control_fsm
    import rv32i_pkg::*;
#(
    parameter int WAIT_TIMEOUT = 16,
    parameter int CNT_W        = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [6:0]       i_opcode,
    input  logic             i_branch_taken,
    input  logic             i_imem_ready,
    input  logic             i_dmem_ready,
    output logic             o_imem_req,
    output logic             o_dmem_req,
    output logic             o_dmem_wren,
    output logic             o_pc_write,
    output logic             o_ir_write,
    output logic             o_reg_write,
    output logic [1:0]       o_alu_src_a,
    output logic [1:0]       o_alu_src_b,
    output logic [1:0]       o_alu_op,
    output logic [1:0]       o_writeback_src,
    output logic [1:0]       o_pc_src,
    output logic             o_instr_retired,
    output logic [CNT_W-1:0] o_retired_count,
    output logic             o_trap,
    output logic [1:0]       o_trap_cause
);

    state_t           r_state;
    logic             r_trap;
    logic [1:0]       r_trap_cause;
    logic [CNT_W-1:0] r_retired_count;

    logic       w_in_wait, w_ready, w_expired;
    logic       w_imem_req, w_dmem_req, w_dmem_wren;
    logic       w_pc_write, w_ir_write, w_reg_write, w_retire;
    logic [1:0] w_alu_src_a, w_alu_src_b, w_alu_op, w_wb_src, w_pc_src;

    assign w_in_wait = (r_state == FETCH) || (r_state == MEM);
    assign w_ready   = (r_state == FETCH) ? i_imem_ready : i_dmem_ready;

    // One timer serves both waits; it restarts whenever no wait is pending or ready arrives
    mc_wait_timer #(.LIMIT(WAIT_TIMEOUT)) u_wait_timer (
        .i_clk     (i_clk),
        .i_clear   (i_reset || !w_in_wait || w_ready),
        .i_tick    (w_in_wait && !w_ready),
        .o_expired (w_expired)
    );

    // Datapath controls decoded from state, the latched opcode and the memory ready lines
    always_comb begin
        w_imem_req  = 1'b0;
        w_dmem_req  = 1'b0;
        w_dmem_wren = 1'b0;
        w_pc_write  = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        w_retire    = 1'b0;
        w_alu_src_a = SRC_A_PC;
        w_alu_src_b = SRC_B_REG;
        w_alu_op    = ALU_ADD;
        w_wb_src    = WB_ALU_OUT;
        w_pc_src    = PC_ALU;
        case (r_state)
            FETCH: begin
                w_imem_req  = 1'b1;
                w_alu_src_b = SRC_B_FOUR;
                w_ir_write  = i_imem_ready;
                w_pc_write  = i_imem_ready;
            end
            DECODE: begin
                w_alu_src_a = SRC_A_FETCH_PC;
                w_alu_src_b = SRC_B_IMM;
            end
            EXECUTE: begin
                case (i_opcode)
                    OPC_OP: begin
                        w_alu_src_a = SRC_A_REG;
                        w_alu_op    = ALU_FUNCT;
                    end
                    OPC_OP_IMM: begin
                        w_alu_src_a = SRC_A_REG;
                        w_alu_src_b = SRC_B_IMM;
                        w_alu_op    = ALU_FUNCT;
                    end
                    OPC_LOAD, OPC_STORE: begin
                        w_alu_src_a = SRC_A_REG;
                        w_alu_src_b = SRC_B_IMM;
                    end
                    OPC_BRANCH: begin
                        w_alu_src_a = SRC_A_REG;
                        w_alu_op    = ALU_BRANCH;
                        w_pc_write  = i_branch_taken;
                        w_pc_src    = i_branch_taken ? PC_ALU_OUT : PC_ALU;
                        w_retire    = 1'b1;
                    end
                    OPC_JAL: begin
                        w_pc_write  = 1'b1;
                        w_pc_src    = PC_ALU_OUT;
                        w_reg_write = 1'b1;
                        w_wb_src    = WB_PC;
                        w_retire    = 1'b1;
                    end
                    OPC_JALR: begin
                        w_alu_src_a = SRC_A_REG;
                        w_alu_src_b = SRC_B_IMM;
                        w_pc_write  = 1'b1;
                        w_pc_src    = PC_ALU_ALIGN;
                        w_reg_write = 1'b1;
                        w_wb_src    = WB_PC;
                        w_retire    = 1'b1;
                    end
                    OPC_LUI: begin
                        w_reg_write = 1'b1;
                        w_wb_src    = WB_IMM;
                        w_retire    = 1'b1;
                    end
                    OPC_AUIPC: begin
                        w_reg_write = 1'b1;
                        w_retire    = 1'b1;
                    end
                    default: ;
                endcase
            end
            MEM: begin
                w_dmem_req  = 1'b1;
                w_dmem_wren = (i_opcode == OPC_STORE);
                w_retire    = (i_opcode == OPC_STORE) && i_dmem_ready;
            end
            WB: begin
                w_reg_write = 1'b1;
                w_wb_src    = (i_opcode == OPC_LOAD) ? WB_MEM : WB_ALU_OUT;
                w_retire    = 1'b1;
            end
            default: ;
        endcase
    end

    // Sequencer state, sticky trap and retire counter
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state         <= FETCH;
            r_trap          <= 1'b0;
            r_trap_cause    <= CAUSE_NONE;
            r_retired_count <= '0;
        end else begin
            if (w_retire) begin
                r_retired_count <= r_retired_count + CNT_W'(1);
            end
            case (r_state)
                FETCH: begin
                    if (w_expired) begin
                        r_state      <= TRAP;
                        r_trap       <= 1'b1;
                        r_trap_cause <= CAUSE_IMEM;
                    end else if (i_imem_ready) begin
                        r_state <= DECODE;
                    end
                end
                DECODE: begin
                    if (!is_legal(i_opcode)) begin
                        r_state      <= TRAP;
                        r_trap       <= 1'b1;
                        r_trap_cause <= CAUSE_ILLEGAL;
                    end else begin
                        r_state <= EXECUTE;
                    end
                end
                EXECUTE: begin
                    case (i_opcode)
                        OPC_OP, OPC_OP_IMM:  r_state <= WB;
                        OPC_LOAD, OPC_STORE: r_state <= MEM;
                        OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: r_state <= FETCH;
                        default: begin
                            r_state      <= TRAP;
                            r_trap       <= 1'b1;
                            r_trap_cause <= CAUSE_ILLEGAL;
                        end
                    endcase
                end
                MEM: begin
                    if (w_expired) begin
                        r_state      <= TRAP;
                        r_trap       <= 1'b1;
                        r_trap_cause <= CAUSE_DMEM;
                    end else if (i_dmem_ready) begin
                        r_state <= (i_opcode == OPC_STORE) ? FETCH : WB;
                    end
                end
                WB:      r_state <= FETCH;
                default: r_state <= TRAP;
            endcase
        end
    end

    // Reset forces every output low in the same cycle, even in the middle of an access
    assign o_imem_req      = w_imem_req  && !i_reset;
    assign o_dmem_req      = w_dmem_req  && !i_reset;
    assign o_dmem_wren     = w_dmem_wren && !i_reset;
    assign o_pc_write      = w_pc_write  && !i_reset;
    assign o_ir_write      = w_ir_write  && !i_reset;
    assign o_reg_write     = w_reg_write && !i_reset;
    assign o_instr_retired = w_retire    && !i_reset;
    assign o_alu_src_a     = i_reset ? 2'b00 : w_alu_src_a;
    assign o_alu_src_b     = i_reset ? 2'b00 : w_alu_src_b;
    assign o_alu_op        = i_reset ? 2'b00 : w_alu_op;
    assign o_writeback_src = i_reset ? 2'b00 : w_wb_src;
    assign o_pc_src        = i_reset ? 2'b00 : w_pc_src;
    assign o_retired_count = i_reset ? '0 : r_retired_count;
    assign o_trap          = r_trap && !i_reset;
    assign o_trap_cause    = i_reset ? CAUSE_NONE : r_trap_cause;

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - directed vector bench for mc_control_fsm
module tb_mc_control_fsm;

    localparam logic [6:0] ADDI  = 7'h13;
    localparam logic [6:0] LW    = 7'h03;
    localparam logic [6:0] SW    = 7'h23;
    localparam logic [6:0] BEQ   = 7'h63;
    localparam logic [6:0] JALR  = 7'h67;
    localparam logic [6:0] JAL   = 7'h6F;
    localparam logic [6:0] LUI   = 7'h37;
    localparam logic [6:0] AUIPC = 7'h17;
    localparam logic [6:0] OPR   = 7'h33;
    localparam logic [6:0] ILL   = 7'h7F;

    logic        clk;
    logic        i_reset;
    logic [6:0]  i_opcode;
    logic        i_branch_taken, i_imem_ready, i_dmem_ready;
    logic        o_imem_req, o_dmem_req, o_dmem_wren, o_pc_write, o_ir_write, o_reg_write;
    logic [1:0]  o_alu_src_a, o_alu_src_b, o_alu_op, o_writeback_src, o_pc_src;
    logic        o_instr_retired, o_trap;
    logic [31:0] o_retired_count;
    logic [1:0]  o_trap_cause;

    mc_control_fsm #(.WAIT_TIMEOUT(4), .CNT_W(32)) dut (
        .i_clk           (clk),
        .i_reset         (i_reset),
        .i_opcode        (i_opcode),
        .i_branch_taken  (i_branch_taken),
        .i_imem_ready    (i_imem_ready),
        .i_dmem_ready    (i_dmem_ready),
        .o_imem_req      (o_imem_req),
        .o_dmem_req      (o_dmem_req),
        .o_dmem_wren     (o_dmem_wren),
        .o_pc_write      (o_pc_write),
        .o_ir_write      (o_ir_write),
        .o_reg_write     (o_reg_write),
        .o_alu_src_a     (o_alu_src_a),
        .o_alu_src_b     (o_alu_src_b),
        .o_alu_op        (o_alu_op),
        .o_writeback_src (o_writeback_src),
        .o_pc_src        (o_pc_src),
        .o_instr_retired (o_instr_retired),
        .o_retired_count (o_retired_count),
        .o_trap          (o_trap),
        .o_trap_cause    (o_trap_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctrl layout: {imem_req,dmem_req,dmem_wren,pc_write,ir_write,reg_write, a,b,op,wb,pc_src, retired,trap,cause}
    typedef struct {
        logic        rst;
        logic [6:0]  opc;
        logic        bt;
        logic        ir;
        logic        dr;
        logic [19:0] ctrl;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;
    int   n;

    logic [19:0] w_act;
    assign w_act = {o_imem_req, o_dmem_req, o_dmem_wren, o_pc_write, o_ir_write, o_reg_write,
                    o_alu_src_a, o_alu_src_b, o_alu_op, o_writeback_src, o_pc_src,
                    o_instr_retired, o_trap, o_trap_cause};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic row(input logic rst, input logic [6:0] opc, input logic bt, input logic ir,
                       input logic dr, input logic [5:0] en, input logic [1:0] a, input logic [1:0] b,
                       input logic [1:0] op, input logic [1:0] wb, input logic [1:0] pcs,
                       input logic ret, input logic trap, input logic [1:0] cause, input logic [31:0] cnt);
        vec_t v;
        v.rst  = rst;
        v.opc  = opc;
        v.bt   = bt;
        v.ir   = ir;
        v.dr   = dr;
        v.ctrl = {en, a, b, op, wb, pcs, ret, trap, cause};
        v.cnt  = cnt;
        vecs.push_back(v);
    endtask

    task automatic fetch_ok(input logic [6:0] opc, input logic [31:0] cnt);
        row(0, opc, 0, 1, 0, 6'b100110, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, cnt);
    endtask

    task automatic decode(input logic [6:0] opc, input logic [31:0] cnt);
        row(0, opc, 0, 1, 0, 6'b000000, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, cnt);
    endtask

    task automatic idle(input logic rst, input logic [6:0] opc, input logic ir, input logic dr,
                        input logic trap, input logic [1:0] cause, input logic [31:0] cnt);
        row(rst, opc, 0, ir, dr, 6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, trap, cause, cnt);
    endtask

    initial begin
        i_reset = 1'b1; i_opcode = ADDI; i_branch_taken = 1'b0;
        i_imem_ready = 1'b1; i_dmem_ready = 1'b0;

        idle(1, ADDI, 1, 0, 0, 2'b00, 0);
        // ADDI
        fetch_ok(ADDI, 0); decode(ADDI, 0);
        row(0, ADDI, 0, 1, 0, 6'b000000, 2'b01, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0, 2'b00, 0);
        row(0, ADDI, 0, 1, 0, 6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 2'b00, 0);
        // LW with three wait cycles
        fetch_ok(LW, 1); decode(LW, 1);
        row(0, LW, 0, 1, 0, 6'b000000, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 1);
        for (int i = 0; i < 3; i++)
            row(0, LW, 0, 1, 0, 6'b010000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 1);
        row(0, LW, 0, 1, 1, 6'b010000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 1);
        row(0, LW, 0, 1, 0, 6'b000001, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 1, 0, 2'b00, 1);
        // SW retires in MEM
        fetch_ok(SW, 2); decode(SW, 2);
        row(0, SW, 0, 1, 0, 6'b000000, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 2);
        row(0, SW, 0, 1, 1, 6'b011000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 2'b00, 2);
        // BEQ taken, then not taken
        fetch_ok(BEQ, 3); decode(BEQ, 3);
        row(0, BEQ, 1, 1, 0, 6'b000100, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 1, 0, 2'b00, 3);
        fetch_ok(BEQ, 4); decode(BEQ, 4);
        row(0, BEQ, 0, 1, 0, 6'b000000, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 1, 0, 2'b00, 4);
        // JALR, JAL, LUI, AUIPC, OP
        fetch_ok(JALR, 5); decode(JALR, 5);
        row(0, JALR, 0, 1, 0, 6'b000101, 2'b01, 2'b10, 2'b00, 2'b11, 2'b10, 1, 0, 2'b00, 5);
        fetch_ok(JAL, 6); decode(JAL, 6);
        row(0, JAL, 0, 1, 0, 6'b000101, 2'b00, 2'b00, 2'b00, 2'b11, 2'b01, 1, 0, 2'b00, 6);
        fetch_ok(LUI, 7); decode(LUI, 7);
        row(0, LUI, 0, 1, 0, 6'b000001, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 1, 0, 2'b00, 7);
        fetch_ok(AUIPC, 8); decode(AUIPC, 8);
        row(0, AUIPC, 0, 1, 0, 6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 2'b00, 8);
        fetch_ok(OPR, 9); decode(OPR, 9);
        row(0, OPR, 0, 1, 0, 6'b000000, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 0, 0, 2'b00, 9);
        row(0, OPR, 0, 1, 0, 6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 2'b00, 9);
        // imem ready arrives on the 4th wait cycle: no trap
        for (int i = 0; i < 3; i++)
            row(0, LUI, 0, 0, 0, 6'b100000, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 10);
        fetch_ok(LUI, 10); decode(LUI, 10);
        row(0, LUI, 0, 1, 0, 6'b000001, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 1, 0, 2'b00, 10);
        // Reset in the middle of MEM
        fetch_ok(LW, 11); decode(LW, 11);
        row(0, LW, 0, 1, 0, 6'b000000, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 11);
        row(0, LW, 0, 1, 0, 6'b010000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 11);
        idle(1, LW, 1, 0, 0, 2'b00, 0);
        fetch_ok(ILL, 0);
        // Illegal opcode traps and stays trapped
        decode(ILL, 0);
        idle(0, ILL, 1, 0, 1, 2'b01, 0);
        idle(0, ILL, 1, 1, 1, 2'b01, 0);
        // imem timeout after four waits
        idle(1, ADDI, 0, 0, 0, 2'b00, 0);
        for (int i = 0; i < 4; i++)
            row(0, ADDI, 0, 0, 0, 6'b100000, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 0);
        idle(0, ADDI, 0, 0, 1, 2'b10, 0);
        idle(0, ADDI, 1, 0, 1, 2'b10, 0);
        // dmem timeout on a store
        idle(1, SW, 1, 0, 0, 2'b00, 0);
        fetch_ok(SW, 0); decode(SW, 0);
        row(0, SW, 0, 1, 0, 6'b000000, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 0);
        for (int i = 0; i < 4; i++)
            row(0, SW, 0, 1, 0, 6'b011000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 0);
        idle(0, SW, 1, 1, 1, 2'b11, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            i_reset        = vecs[i].rst;
            i_opcode       = vecs[i].opc;
            i_branch_taken = vecs[i].bt;
            i_imem_ready   = vecs[i].ir;
            i_dmem_ready   = vecs[i].dr;
            #1;
            check($sformatf("row%0d_ctrl", i), 32'(w_act), 32'(vecs[i].ctrl));
            check($sformatf("row%0d_count", i), o_retired_count, vecs[i].cnt);
        end

        // Back-to-back ADDIs: each takes four cycles and bumps the retire count once
        @(negedge clk);
        i_reset = 1'b1; i_opcode = ADDI; i_imem_ready = 1'b1; i_dmem_ready = 1'b0; i_branch_taken = 1'b0;
        @(negedge clk);
        i_reset = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            n = 1;
            while (!o_instr_retired && n < 10) begin
                @(negedge clk);
                #1;
                n++;
            end
            check($sformatf("addi%0d_cycles", k), n, 4);
            check($sformatf("addi%0d_wb_regwrite", k), 32'(o_reg_write), 32'd1);
            @(negedge clk);
            #1;
        end
        check("addi_retired_total", o_retired_count, 32'd5);
        check("addi_back_in_fetch", 32'(o_imem_req), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
